// File: rtl/ssp_tx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ssp_tx_fifo_ctrl
//   Pointer and flag controller for the SSP transmit FIFO register file
//   (2**ADDR_W entries, 16 bits wide). The register file itself lives
//   outside this block: it writes entry WrPtr when RegFileWrEn is high and
//   reads entry RdPtr combinationally.
//
// Optional build macro: SSP_TX_OVERFLOW_FLAG_EN
//   When defined, adds TxOvfClr (input) and TxOvf (sticky overflow output).
//
// Ports
//   PCLK, PRESETn  APB clock, asynchronous active-low reset
//   TxPushReq      APB write to the data register (1-cycle strobe)
//   TxPopReq       serial engine consumes the word on the read data bus
//   TxFifoClr      synchronous flush; wins over same-cycle push/pop
//   RegFileWrEn    register file write enable (accepted push)
//   WrPtr, RdPtr   register file write / read pointers
//   TxFCount       occupancy 0..2**ADDR_W
//   TxFEmpty       count == 0
//   TxFNotFull     count != 2**ADDR_W
//   TxIntLevel     count <= half depth (half-empty interrupt source)
//   TxOvfClr/TxOvf optional overflow clear / sticky flag
// ---------------------------------------------------------------------------
module ssp_tx_fifo_ctrl #(
  parameter int ADDR_W = 3
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              TxPushReq,
  input  logic              TxPopReq,
  input  logic              TxFifoClr,
  output logic              RegFileWrEn,
  output logic [ADDR_W-1:0] WrPtr,
  output logic [ADDR_W-1:0] RdPtr,
  output logic [ADDR_W:0]   TxFCount,
  output logic              TxFEmpty,
  output logic              TxFNotFull,
  output logic              TxIntLevel
`ifdef SSP_TX_OVERFLOW_FLAG_EN
  ,
  input  logic              TxOvfClr,
  output logic              TxOvf
`endif
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] HALF  = DEPTH >> 1;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  logic w_empty;
  logic w_not_full;
  logic w_push_acc;
  logic w_pop_acc;

  // Status flags decode the registered count only, so acceptance never
  // depends on same-cycle activity (no fall-through on full or empty).
  assign w_empty    = (r_count == '0);
  assign w_not_full = (r_count != DEPTH);

  assign w_push_acc = TxPushReq & w_not_full & ~TxFifoClr;
  assign w_pop_acc  = TxPopReq  & ~w_empty   & ~TxFifoClr;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (TxFifoClr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally at 2**ADDR_W.
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Gated by reset so no write can reach the register file while the
  // controller is held in reset with a push strobe still high.
  assign RegFileWrEn = w_push_acc & PRESETn;
  assign WrPtr       = r_wr_ptr;
  assign RdPtr       = r_rd_ptr;
  assign TxFCount    = r_count;
  assign TxFEmpty    = w_empty;
  assign TxFNotFull  = w_not_full;
  assign TxIntLevel  = (r_count <= HALF);

`ifdef SSP_TX_OVERFLOW_FLAG_EN
  logic r_ovf;
  logic w_ovf_set;

  // A dropped push (full, not being flushed) sets the sticky flag; set
  // beats clear when both occur in one cycle.
  assign w_ovf_set = TxPushReq & ~w_not_full & ~TxFifoClr;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                    r_ovf <= 1'b0;
    else if (w_ovf_set)              r_ovf <= 1'b1;
    else if (TxOvfClr || TxFifoClr)  r_ovf <= 1'b0;
  end

  assign TxOvf = r_ovf;
`endif

endmodule

// File: tb/tb_ssp_tx_fifo_ctrl.sv
module tb_ssp_tx_fifo_ctrl;

  logic        PCLK;
  logic        PRESETn;
  logic        TxPushReq, TxPopReq, TxFifoClr;
  logic        RegFileWrEn;
  logic [2:0]  WrPtr, RdPtr;
  logic [3:0]  TxFCount;
  logic        TxFEmpty, TxFNotFull, TxIntLevel;
  logic        TxOvfClr;
  logic        TxOvf;
  logic [15:0] wdata;

  ssp_tx_fifo_ctrl #(.ADDR_W(3)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .TxPushReq   (TxPushReq),
    .TxPopReq    (TxPopReq),
    .TxFifoClr   (TxFifoClr),
    .RegFileWrEn (RegFileWrEn),
    .WrPtr       (WrPtr),
    .RdPtr       (RdPtr),
    .TxFCount    (TxFCount),
    .TxFEmpty    (TxFEmpty),
    .TxFNotFull  (TxFNotFull),
    .TxIntLevel  (TxIntLevel)
`ifdef SSP_TX_OVERFLOW_FLAG_EN
    ,
    .TxOvfClr    (TxOvfClr),
    .TxOvf       (TxOvf)
`endif
  );

`ifndef SSP_TX_OVERFLOW_FLAG_EN
  assign TxOvf = 1'b0;
`endif

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Model of the external register file, written from the DUT's strobe.
  logic [15:0] mem [8];
  always @(posedge PCLK) if (RegFileWrEn) mem[WrPtr] <= wdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input int cnt);
    chk({tag, " TxFEmpty"},   int'(TxFEmpty),   int'(cnt == 0));
    chk({tag, " TxFNotFull"}, int'(TxFNotFull), int'(cnt != 8));
    chk({tag, " TxIntLevel"}, int'(TxIntLevel), int'(cnt <= 4));
  endtask

  typedef struct {
    bit          push, pop, clr, oclr;
    logic [15:0] wd;
    bit          wen;
    int          wr, rd, cnt;
    bit          ovf;
    bit          crd;
    logic [15:0] rdat;
  } vec_t;

  function automatic vec_t mk(bit pu, bit po, bit cl, bit oc, logic [15:0] wd,
                              bit wen, int wr, int rd, int cnt, bit ovf,
                              bit crd, logic [15:0] rdat);
    vec_t v;
    v.push = pu; v.pop = po; v.clr = cl; v.oclr = oc; v.wd = wd;
    v.wen = wen; v.wr = wr; v.rd = rd; v.cnt = cnt; v.ovf = ovf;
    v.crd = crd; v.rdat = rdat;
    return v;
  endfunction

  vec_t vt [$];

  initial begin
    // push pop clr oclr wdata | wen wr rd cnt ovf | chk_rd rdata
    vt.push_back(mk(1,0,0,0,16'h1111, 1,1,0,1,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'h2222, 1,2,0,2,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'h3333, 1,3,0,3,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'h4444, 1,4,0,4,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'h5555, 1,5,0,5,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'h6666, 1,6,0,6,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'h7777, 1,7,0,7,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'h8888, 1,0,0,8,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'hDEAD, 0,0,0,8,1, 0,16'h0)); // dropped push
    vt.push_back(mk(0,1,0,1,16'h0,    0,0,1,7,0, 1,16'h1111));
    vt.push_back(mk(0,1,0,0,16'h0,    0,0,2,6,0, 1,16'h2222));
    vt.push_back(mk(0,1,0,0,16'h0,    0,0,3,5,0, 1,16'h3333));
    vt.push_back(mk(0,1,0,0,16'h0,    0,0,4,4,0, 1,16'h4444));
    vt.push_back(mk(0,1,0,0,16'h0,    0,0,5,3,0, 1,16'h5555));
    vt.push_back(mk(0,1,0,0,16'h0,    0,0,6,2,0, 1,16'h6666));
    vt.push_back(mk(0,1,0,0,16'h0,    0,0,7,1,0, 1,16'h7777));
    vt.push_back(mk(0,1,0,0,16'h0,    0,0,0,0,0, 1,16'h8888));
    vt.push_back(mk(0,1,0,0,16'h0,    0,0,0,0,0, 0,16'h0));   // pop on empty
    vt.push_back(mk(1,1,0,0,16'hAAAA, 1,1,0,1,0, 0,16'h0));   // both at 0
    vt.push_back(mk(1,0,0,0,16'hBBBB, 1,2,0,2,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'hCCCC, 1,3,0,3,0, 0,16'h0));
    vt.push_back(mk(1,1,0,0,16'hDDDD, 1,4,1,3,0, 1,16'hAAAA)); // both at 3
    vt.push_back(mk(1,0,0,0,16'hE001, 1,5,1,4,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'hE002, 1,6,1,5,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'hE003, 1,7,1,6,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'hE004, 1,0,1,7,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'hE005, 1,1,1,8,0, 0,16'h0));
    vt.push_back(mk(1,1,0,0,16'hFFFF, 0,1,2,7,1, 1,16'hBBBB)); // both at 8
    vt.push_back(mk(0,1,0,0,16'h0,    0,1,3,6,1, 1,16'hCCCC));
    vt.push_back(mk(0,1,0,0,16'h0,    0,1,4,5,1, 1,16'hDDDD));
    vt.push_back(mk(1,0,1,0,16'h1234, 0,0,0,0,0, 0,16'h0));   // clear at 5
    vt.push_back(mk(1,0,0,0,16'h5A5A, 1,1,0,1,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'h5A5B, 1,2,0,2,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'h5A5C, 1,3,0,3,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'h5A5D, 1,4,0,4,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'h5A5E, 1,5,0,5,0, 0,16'h0));
    vt.push_back(mk(1,0,0,0,16'h5A5F, 1,6,0,6,0, 0,16'h0));

    PRESETn = 1'b0; TxPushReq = 0; TxPopReq = 0; TxFifoClr = 0; TxOvfClr = 0;
    wdata = '0;
    #1;
    chk("rst WrPtr",       int'(WrPtr),       0);
    chk("rst RdPtr",       int'(RdPtr),       0);
    chk("rst TxFCount",    int'(TxFCount),    0);
    chk("rst RegFileWrEn", int'(RegFileWrEn), 0);
    chk_flags("rst", 0);
`ifdef SSP_TX_OVERFLOW_FLAG_EN
    chk("rst TxOvf", int'(TxOvf), 0);
`endif
    @(negedge PCLK); @(negedge PCLK);
    PRESETn = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      @(negedge PCLK);
      TxPushReq = vt[i].push; TxPopReq = vt[i].pop;
      TxFifoClr = vt[i].clr;  TxOvfClr = vt[i].oclr; wdata = vt[i].wd;
      #1;
      chk({tag, " RegFileWrEn"}, int'(RegFileWrEn), int'(vt[i].wen));
      if (vt[i].crd) chk({tag, " rdata"}, int'(mem[RdPtr]), int'(vt[i].rdat));
      @(posedge PCLK); #1;
      chk({tag, " WrPtr"},    int'(WrPtr),    vt[i].wr);
      chk({tag, " RdPtr"},    int'(RdPtr),    vt[i].rd);
      chk({tag, " TxFCount"}, int'(TxFCount), vt[i].cnt);
      chk_flags(tag, vt[i].cnt);
`ifdef SSP_TX_OVERFLOW_FLAG_EN
      chk({tag, " TxOvf"}, int'(TxOvf), int'(vt[i].ovf));
`endif
    end

    // Asynchronous reset mid-push at count 6: outputs must clear before
    // the next rising edge.
    @(negedge PCLK);
    TxPushReq = 1; TxPopReq = 0; TxFifoClr = 0; TxOvfClr = 0; wdata = 16'h7E7E;
    #2 PRESETn = 1'b0;
    #1;
    chk("arst WrPtr",       int'(WrPtr),       0);
    chk("arst RdPtr",       int'(RdPtr),       0);
    chk("arst TxFCount",    int'(TxFCount),    0);
    chk("arst RegFileWrEn", int'(RegFileWrEn), 0);
    chk_flags("arst", 0);
`ifdef SSP_TX_OVERFLOW_FLAG_EN
    chk("arst TxOvf", int'(TxOvf), 0);
`endif
    @(negedge PCLK);
    TxPushReq = 0;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("post-rst TxFCount", int'(TxFCount), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ssp_tx_fifo_ctrl.md
Name: ssp_tx_fifo_ctrl

Overview:
- Pointer and flag controller for the SSP transmit FIFO register file (8 x 16-bit).
- Accepts APB-side push requests and serial-side pop requests.
- Drives the register file write enable, write pointer and read pointer.
- Maintains the occupancy count, full/empty status and the transmit half-empty interrupt level.

Parameters:
- ADDR_W, 3, pointer width; FIFO depth = 2**ADDR_W (8 entries; the register file is sized for 3).

Ports:
- PCLK  input  1  APB bus clock
- PRESETn  input  1  APB bus reset, asynchronous, active-low
- TxPushReq  input  1  APB write to the SSP data register (single-cycle strobe)
- TxPopReq  input  1  serial engine consumes the word currently on the register file read data bus
- TxFifoClr  input  1  synchronous flush (SSP disable/clear)
- RegFileWrEn  output  1  write enable to the register file
- WrPtr  output  ADDR_W  register file write pointer
- RdPtr  output  ADDR_W  register file read pointer
- TxFCount  output  ADDR_W+1  number of valid entries, 0..8
- TxFEmpty  output  1  count == 0
- TxFNotFull  output  1  count != 8
- TxIntLevel  output  1  count <= 4 (transmit half-empty interrupt source)

Behaviour:
- Reset (PRESETn low, asynchronous): WrPtr=0, RdPtr=0, TxFCount=0, TxFEmpty=1, TxFNotFull=1, TxIntLevel=1, RegFileWrEn=0.
- Acceptance is decided from the current registered count only:
  - PushAcc = TxPushReq & TxFNotFull & ~TxFifoClr.
  - PopAcc = TxPopReq & ~TxFEmpty & ~TxFifoClr.
- RegFileWrEn = PushAcc, combinational. Data is written to entry WrPtr at the same PCLK edge at which WrPtr increments.
- Push latency: a word pushed in cycle N is visible on the read data bus from cycle N+1 if the FIFO was empty.
- Read data is combinational from RdPtr. The consumer samples the data while asserting TxPopReq. RdPtr increments at that edge.
- Pointers wrap modulo 2**ADDR_W (7 -> 0). No special case is applied at wrap.
- TxFCount next value:
  - +1 on PushAcc only.
  - -1 on PopAcc only.
  - Unchanged when both or neither are accepted.
- Full with simultaneous push and pop: the push is rejected (count-based decision) and the pop is accepted, so the count goes 8 -> 7. No fall-through is allowed.
- Empty with simultaneous push and pop: the pop is ignored and the push is accepted, so the count goes 0 -> 1.
- Push when full: silently dropped. No pointer or count change and RegFileWrEn stays 0.
- Pop when empty: ignored.
- TxFifoClr: next state is WrPtr=0, RdPtr=0, count=0. It has priority over same-cycle push and pop. Register file contents are untouched (stale data is never read because the FIFO is empty).
- TxFEmpty, TxFNotFull and TxIntLevel are combinational decodes of the registered TxFCount. They change the cycle after the causing edge with no extra latency.
- Reset asserted mid-operation: all state returns immediately to reset values. Any push in flight is lost.

Optional Feature:
- Macro: SSP_TX_OVERFLOW_FLAG_EN.
- When defined, the block adds:
  - Input TxOvfClr (1 bit).
  - Output TxOvf (1 bit, registered, sticky).
- TxOvf behaviour:
  - Set at the edge following any cycle with TxPushReq & ~TxFNotFull & ~TxFifoClr.
  - Cleared by TxOvfClr or TxFifoClr.
  - Set has priority over TxOvfClr in the same cycle.
  - Reset value 0.
- When not defined, neither port exists and dropped pushes leave no trace.

Test Plan:
- Reset, then 8 single-cycle pushes of 0x1111..0x8888: WrPtr walks 0..7 then wraps to 0; TxFCount=8; TxFNotFull=0 after the 8th edge; TxIntLevel=0 once count reaches 5.
- From full, a 9th push of 0xDEAD: RegFileWrEn=0, WrPtr stays 0, count stays 8; with SSP_TX_OVERFLOW_FLAG_EN, TxOvf=1 the next cycle and cleared one cycle after TxOvfClr.
- From full, 8 pops: RdPtr 0..7 then wraps to 0, popped data is 0x1111..0x8888 in order, TxFEmpty=1 at the end, and a 9th pop leaves RdPtr=0.
- At count=3 with push and pop together: count stays 3 and both pointers advance by 1. At count=0 with both: count=1 and RdPtr unchanged. At count=8 with both: count=7 and WrPtr unchanged.
- At count=5 with TxFifoClr and TxPushReq in the same cycle: next cycle pointers=0, count=0, TxFEmpty=1, RegFileWrEn=0 during the clear cycle.
- PRESETn asserted asynchronously mid-push at count=6: outputs immediately return to reset values without waiting for PCLK.
